sliding_window_vproc: RTL

Parametrised successor to the fixed 8-bit, 10-tap streaming window processor. It holds the last WIN samples of an input stream, exposes them as taps, and produces one registered reduction result per accepted sample once the window is full. The reduction is run-time selectable: saturating sum, max, min or range. Adds a valid handshake, a synchronous flush, a fill counter and an optional signed mode. It sits directly after the stream source in the vector datapath.

---
 rtl/swvp_pkg.sv | 40 ++++
 rtl/swvp_reduce.sv | 27 ++
 rtl/sliding_window_vproc.sv | 99 +++++++++
 3 files changed

// File: rtl/swvp_pkg.sv
// rtl/swvp_pkg.sv - mode codes, width helpers and saturation for sliding_window_vproc
// Define SWVP_SIGNED_EN to switch all sample arithmetic to two's complement.
package swvp_pkg;

  localparam logic [1:0] MODE_SAT_SUM = 2'd0;
  localparam logic [1:0] MODE_MAX     = 2'd1;
  localparam logic [1:0] MODE_MIN     = 2'd2;
  localparam logic [1:0] MODE_RANGE   = 2'd3;

`ifdef SWVP_SIGNED_EN
  localparam bit SWVP_SIGNED = 1'b1;
`else
  localparam bit SWVP_SIGNED = 1'b0;
`endif

  function automatic int cnt_width(input int win);
    return $clog2(win + 1);
  endfunction

  function automatic int acc_width(input int data_w, input int win);
    return data_w + $clog2(win);
  endfunction

  // Clamp a sign-extended running sum into the representable sample range.
  function automatic logic signed [63:0] saturate(input logic signed [63:0] v, input int data_w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    if (SWVP_SIGNED) begin
      hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (data_w - 1));
    end else begin
      hi = (64'sd1 <<< data_w) - 64'sd1;
      lo = 64'sd0;
    end
    if (v > hi)      return hi;
    else if (v < lo) return lo;
    else             return v;
  endfunction

endpackage

// File: rtl/swvp_reduce.sv
// rtl/swvp_reduce.sv - combinational max/min over the flattened window taps
// Signed compares flip the sign bit so a single unsigned comparator serves both builds.
module swvp_reduce
  import swvp_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int WIN    = 10
)(
  input  logic [WIN*DATA_W-1:0] i_taps,
  output logic [DATA_W-1:0]     o_max,
  output logic [DATA_W-1:0]     o_min
);

  function automatic logic [DATA_W-1:0] cmp_key(input logic [DATA_W-1:0] v);
    return {v[DATA_W-1] ^ SWVP_SIGNED, v[DATA_W-2:0]};
  endfunction

  always_comb begin
    o_max = i_taps[DATA_W-1:0];
    o_min = i_taps[DATA_W-1:0];
    for (int i = 1; i < WIN; i++) begin
      if (cmp_key(i_taps[i*DATA_W +: DATA_W]) > cmp_key(o_max)) o_max = i_taps[i*DATA_W +: DATA_W];
      if (cmp_key(i_taps[i*DATA_W +: DATA_W]) < cmp_key(o_min)) o_min = i_taps[i*DATA_W +: DATA_W];
    end
  end

endmodule

// File: rtl/sliding_window_vproc.sv
// rtl/sliding_window_vproc.sv - WIN-tap sliding window with registered sum/max/min/range result
// SWVP_SIGNED_EN (see swvp_pkg) selects two's-complement samples; ports are identical either way.
module sliding_window_vproc
  import swvp_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int WIN    = 10,
  parameter int CNT_W  = cnt_width(WIN),
  parameter int ACC_W  = acc_width(DATA_W, WIN)
)(
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_in_valid,
  input  logic [DATA_W-1:0]     i_next_in,
  input  logic                  i_flush,
  input  logic [1:0]            i_mode,
  output logic [WIN*DATA_W-1:0] o_taps,
  output logic [CNT_W-1:0]      o_fill,
  output logic                  o_win_full,
  output logic                  o_out_valid,
  output logic [DATA_W-1:0]     o_f
);

  logic [WIN*DATA_W-1:0] r_taps;
  logic [CNT_W-1:0]      r_fill;
  logic [ACC_W-1:0]      r_sum;
  logic                  r_pend;
  logic                  r_out_valid;
  logic [DATA_W-1:0]     r_f;

  logic                  w_full;
  logic [DATA_W-1:0]     w_evict;
  logic [ACC_W-1:0]      w_in_ext;
  logic [ACC_W-1:0]      w_ev_ext;
  logic signed [63:0]    w_sum64;
  logic [DATA_W-1:0]     w_max;
  logic [DATA_W-1:0]     w_min;
  logic [DATA_W-1:0]     w_res;

  assign w_full   = (r_fill == CNT_W'(WIN));
  assign w_evict  = w_full ? r_taps[WIN*DATA_W-1 -: DATA_W] : '0;
  assign w_in_ext = {{(ACC_W-DATA_W){SWVP_SIGNED & i_next_in[DATA_W-1]}}, i_next_in};
  assign w_ev_ext = {{(ACC_W-DATA_W){SWVP_SIGNED & w_evict[DATA_W-1]}}, w_evict};
  assign w_sum64  = {{(64-ACC_W){SWVP_SIGNED & r_sum[ACC_W-1]}}, r_sum};

  swvp_reduce #(
    .DATA_W (DATA_W),
    .WIN    (WIN)
  ) u_reduce (
    .i_taps (r_taps),
    .o_max  (w_max),
    .o_min  (w_min)
  );

  // Max is never below min, so the modular difference is the true range in both builds.
  always_comb begin
    w_res = w_max - w_min;
    case (i_mode)
      MODE_SAT_SUM: w_res = DATA_W'(saturate(w_sum64, DATA_W));
      MODE_MAX:     w_res = w_max;
      MODE_MIN:     w_res = w_min;
      default:      w_res = w_max - w_min;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_taps      <= '0;
      r_fill      <= '0;
      r_sum       <= '0;
      r_pend      <= 1'b0;
      r_out_valid <= 1'b0;
      r_f         <= '0;
    end else if (i_flush) begin
      r_taps      <= '0;
      r_fill      <= '0;
      r_sum       <= '0;
      r_pend      <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_pend      <= i_in_valid;
      r_out_valid <= r_pend & w_full;
      if (r_pend & w_full) r_f <= w_res;
      // Sum is maintained incrementally: add the arrival, drop the evicted tap.
      if (i_in_valid) begin
        r_taps <= {r_taps[(WIN-1)*DATA_W-1:0], i_next_in};
        r_fill <= w_full ? r_fill : r_fill + 1'b1;
        r_sum  <= r_sum + w_in_ext - w_ev_ext;
      end
    end
  end

  assign o_taps      = r_taps;
  assign o_fill      = r_fill;
  assign o_win_full  = w_full;
  assign o_out_valid = r_out_valid;
  assign o_f         = r_f;

endmodule
